aes_key_schedule_iter: RTL and testbench

//   Iterative, word-serial AES key expansion for AES-128/192/256, with the key length selected per request.

---
 rtl/aes_pkg.sv | 88 ++++++++
 rtl/aes_sub_word.sv | 16 +
 rtl/aes_key_schedule_iter.sv | 158 +++++++++++++++
 tb/tb_aes_key_schedule_iter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES key schedule.
//   key_len_e      : request key-length encoding (00=128, 01=192, 10=256, 11=reserved)
//   nk_of/nr_of/nw_of/key_bits_of : per-length key words, rounds, schedule words, key bits
//   xtime          : GF(2^8) multiply-by-2 used to advance rcon
//   AES_SBOX       : forward S-box table
package aes_pkg;

  typedef enum logic [1:0] {
    KeyLen128  = 2'b00,
    KeyLen192  = 2'b01,
    KeyLen256  = 2'b10,
    KeyLenRsvd = 2'b11
  } key_len_e;

  function automatic logic [3:0] nk_of(key_len_e len);
    case (len)
      KeyLen192: return 4'd6;
      KeyLen256: return 4'd8;
      default:   return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(key_len_e len);
    case (len)
      KeyLen192: return 4'd12;
      KeyLen256: return 4'd14;
      default:   return 4'd10;
    endcase
  endfunction

  function automatic logic [5:0] nw_of(key_len_e len);
    case (len)
      KeyLen192: return 6'd52;
      KeyLen256: return 6'd60;
      default:   return 6'd44;
    endcase
  endfunction

  // Reserved encoding reports 0 bits; callers reject it separately.
  function automatic int unsigned key_bits_of(key_len_e len);
    case (len)
      KeyLen128: return 128;
      KeyLen192: return 192;
      KeyLen256: return 256;
      default:   return 0;
    endcase
  endfunction

  function automatic logic [7:0] xtime(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  localparam logic [7:0] AES_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel combinational S-box lookups.
//   din  : 32-bit input word
//   dout : 32-bit word with every byte substituted
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  assign dout[31:24] = AES_SBOX[din[31:24]];
  assign dout[23:16] = AES_SBOX[din[23:16]];
  assign dout[15:8]  = AES_SBOX[din[15:8]];
  assign dout[7:0]   = AES_SBOX[din[7:0]];

endmodule

// File: rtl/aes_key_schedule_iter.sv
// Iterative word-serial AES-128/192/256 key expansion with a registered round-key read port.
//   clk, rst_n            : clock, synchronous active-low reset
//   key_valid/key_ready   : request handshake; key_len selects 128/192/256 (11 reserved)
//   key_in                : MSB-justified cipher key, w[0] = key_in[255:224]
//   busy, done, keys_valid, err : status (done and err are 1-cycle pulses)
//   rk_rd_en/rk_rd_idx    : round-key read request
//   rk_rd_data/rk_rd_vld  : {w[4i],w[4i+1],w[4i+2],w[4i+3]}, one cycle after the request
module aes_key_schedule_iter
  import aes_pkg::*;
#(
  parameter int unsigned MAX_KEY_BITS = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  output logic         err,
  input  logic         rk_rd_en,
  input  logic [3:0]   rk_rd_idx,
  output logic [127:0] rk_rd_data,
  output logic         rk_rd_vld
);

  localparam int unsigned MAX_NW = 4 * (MAX_KEY_BITS / 32) + 28;

  typedef enum logic [0:0] {StIdle, StExpand} state_e;

  state_e       state_q;
  key_len_e     mode_q;
  logic [5:0]   idx_q;   // index of the word being produced
  logic [2:0]   pos_q;   // idx_q mod Nk, kept as a wrap counter
  logic [7:0]   rcon_q;
  logic         done_q, keys_valid_q, err_q, rd_vld_q;
  logic [127:0] rd_data_q;
  logic [31:0]  w_q [MAX_NW];

  key_len_e     req_len;
  logic         req_bad, accept, step, last;
  logic [3:0]   nk;
  logic [31:0]  prev_w, back_w, sub_in, sub_out, new_w;
  logic [5:0]   rd_base;
  logic [127:0] rd_word;

  assign req_len = key_len_e'(key_len);
  assign req_bad = (req_len == KeyLenRsvd) || (key_bits_of(req_len) > MAX_KEY_BITS);
  assign accept  = key_valid && (state_q == StIdle);
  assign step    = (state_q == StExpand);
  assign nk      = nk_of(mode_q);
  assign last    = (idx_q == nw_of(mode_q) - 6'd1);

  assign prev_w  = w_q[idx_q - 6'd1];
  assign back_w  = w_q[idx_q - {2'b00, nk}];
  // One S-box bank serves both the RotWord case and the 256-bit mid-block case.
  assign sub_in  = (pos_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

  aes_sub_word u_sub_word (
    .din  (sub_in),
    .dout (sub_out)
  );

  always_comb begin
    new_w = back_w ^ prev_w;
    if (pos_q == 3'd0) begin
      new_w = back_w ^ sub_out ^ {rcon_q, 24'h000000};
    end else if ((nk == 4'd8) && (pos_q == 3'd4)) begin
      new_w = back_w ^ sub_out;
    end
  end

  // Out-of-range round index (beyond Nr of the stored mode, hence also beyond 14) reads zero.
  always_comb begin
    rd_base = {rk_rd_idx, 2'b00};
    rd_word = '0;
    if (rk_rd_idx <= nr_of(mode_q)) begin
      rd_word = {w_q[rd_base], w_q[rd_base + 6'd1], w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      mode_q       <= KeyLen128;
      idx_q        <= '0;
      pos_q        <= '0;
      rcon_q       <= 8'h01;
      done_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      err_q        <= 1'b0;
      rd_vld_q     <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rd_vld_q <= rk_rd_en;
      if (rk_rd_en) begin
        rd_data_q <= rd_word;
      end
      unique case (state_q)
        StIdle: begin
          if (key_valid) begin
            if (req_bad) begin
              err_q <= 1'b1;
            end else begin
              state_q      <= StExpand;
              mode_q       <= req_len;
              idx_q        <= {2'b00, nk_of(req_len)};
              pos_q        <= '0;
              rcon_q       <= 8'h01;
              keys_valid_q <= 1'b0;
            end
          end
        end
        StExpand: begin
          idx_q <= idx_q + 6'd1;
          pos_q <= ({1'b0, pos_q} == nk - 4'd1) ? 3'd0 : pos_q + 3'd1;
          if (pos_q == 3'd0) begin
            rcon_q <= xtime(rcon_q);
          end
          if (last) begin
            state_q      <= StIdle;
            done_q       <= 1'b1;
            keys_valid_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Word storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (accept && !req_bad) begin
        for (int unsigned k = 0; k < 8; k++) begin
          if (k < 32'(nk_of(req_len))) begin
            w_q[k[5:0]] <= key_in[255 - 32 * k -: 32];
          end
        end
      end else if (step) begin
        w_q[idx_q] <= new_w;
      end
    end
  end

  assign key_ready  = (state_q == StIdle);
  assign busy       = (state_q == StExpand);
  assign done       = done_q;
  assign keys_valid = keys_valid_q;
  assign err        = err_q;
  assign rk_rd_data = rd_data_q;
  assign rk_rd_vld  = rd_vld_q;

endmodule

// File: tb/tb_aes_key_schedule_iter.sv
module tb_aes_key_schedule_iter;

  logic         clk = 1'b0;
  logic         rst_n, key_valid, key_valid2, rk_rd_en;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic [3:0]   rk_rd_idx;

  logic         key_ready, busy, done, keys_valid, err, rk_rd_vld;
  logic [127:0] rk_rd_data;
  logic         key_ready2, busy2, done2, keys_valid2, err2, rk_rd_vld2;
  logic [127:0] rk_rd_data2;

  always #5 clk = ~clk;

  aes_key_schedule_iter #(.MAX_KEY_BITS(256)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
    .key_len(key_len), .key_in(key_in), .busy(busy), .done(done),
    .keys_valid(keys_valid), .err(err), .rk_rd_en(rk_rd_en), .rk_rd_idx(rk_rd_idx),
    .rk_rd_data(rk_rd_data), .rk_rd_vld(rk_rd_vld)
  );

  aes_key_schedule_iter #(.MAX_KEY_BITS(128)) dut128 (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid2), .key_ready(key_ready2),
    .key_len(key_len), .key_in(key_in), .busy(busy2), .done(done2),
    .keys_valid(keys_valid2), .err(err2), .rk_rd_en(rk_rd_en), .rk_rd_idx(rk_rd_idx),
    .rk_rd_data(rk_rd_data2), .rk_rd_vld(rk_rd_vld2)
  );

  int n_checks = 0;
  int n_err = 0;
  bit err_seen = 1'b0;

  localparam logic [127:0] A1_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] A3_RK14 = 128'hfe4890d1e6188d0b046df344706c631e;

  typedef struct {
    logic [1:0]   len;
    logic [255:0] key;
    int           cycles;
  } vec_t;

  typedef struct {
    int           vec;
    logic [3:0]   idx;
    logic [127:0] exp;
  } rd_t;

  vec_t vecs[3];
  rd_t  rds[14];

  task automatic chk_w(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk_b({tag, "_key_ready"}, key_ready, 1'b1);
    chk_b({tag, "_busy"}, busy, 1'b0);
    chk_b({tag, "_done"}, done, 1'b0);
    chk_b({tag, "_keys_valid"}, keys_valid, 1'b0);
    chk_b({tag, "_err"}, err, 1'b0);
    chk_b({tag, "_rd_vld"}, rk_rd_vld, 1'b0);
    chk_w({tag, "_rd_data"}, rk_rd_data, 128'h0);
  endtask

  // Returns just after the accepting edge; key_valid stays high when hold is set.
  task automatic accept_key(input logic [1:0] len, input logic [255:0] key, input bit hold);
    int n = 0;
    key_len   = len;
    key_in    = key;
    key_valid = 1'b1;
    while (!key_ready && n < 100) begin
      tick();
      n++;
    end
    chk_b("accept_wait", n < 100, 1'b1);
    tick();
    if (!hold) key_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_cycles);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 200) begin
      tick();
      n++;
      seen = done;
      if (err) err_seen = 1'b1;
    end
    chk_i({name, "_done_cycle"}, n, exp_cycles);
    chk_b({name, "_busy_low"}, busy, 1'b0);
    chk_b({name, "_ready_high"}, key_ready, 1'b1);
    chk_b({name, "_keys_valid"}, keys_valid, 1'b1);
  endtask

  task automatic read_rk(input string name, input logic [3:0] idx, input logic [127:0] exp);
    rk_rd_en  = 1'b1;
    rk_rd_idx = idx;
    tick();
    rk_rd_en = 1'b0;
    chk_b({name, "_vld"}, rk_rd_vld, 1'b1);
    chk_w(name, rk_rd_data, exp);
    tick();
    chk_b({name, "_vld_drop"}, rk_rd_vld, 1'b0);
    chk_w({name, "_hold"}, rk_rd_data, exp);
  endtask

  initial begin
    int n;

    vecs[0] = '{2'b00, {A1_KEY, 128'hdeadbeef0badf00d123456789abcdef0}, 40};
    vecs[1] = '{2'b01, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                        64'hffffffffffffffff}, 46};
    vecs[2] = '{2'b10, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                52};

    rds[0]  = '{0, 4'd0,  A1_KEY};
    rds[1]  = '{0, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    rds[2]  = '{0, 4'd10, A1_RK10};
    rds[3]  = '{0, 4'd11, 128'h0};
    rds[4]  = '{0, 4'd15, 128'h0};
    rds[5]  = '{1, 4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5};
    rds[6]  = '{1, 4'd1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5};
    rds[7]  = '{1, 4'd12, 128'he98ba06f448c773c8ecc720401002202};
    rds[8]  = '{1, 4'd13, 128'h0};
    rds[9]  = '{2, 4'd0,  128'h603deb1015ca71be2b73aef0857d7781};
    rds[10] = '{2, 4'd1,  128'h1f352c073b6108d72d9810a30914dff4};
    rds[11] = '{2, 4'd2,  128'h9ba354118e6925afa51a8b5f2067fcde};
    rds[12] = '{2, 4'd14, A3_RK14};
    rds[13] = '{2, 4'd15, 128'h0};

    rst_n = 1'b0; key_valid = 1'b0; key_valid2 = 1'b0; rk_rd_en = 1'b0;
    rk_rd_idx = '0; key_len = '0; key_in = '0;
    tick();
    tick();
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    // FIPS-197 A.1/A.2/A.3 vectors.
    for (int v = 0; v < 3; v++) begin
      accept_key(vecs[v].len, vecs[v].key, 1'b0);
      chk_b($sformatf("v%0d_busy", v), busy, 1'b1);
      chk_b($sformatf("v%0d_ready_low", v), key_ready, 1'b0);
      chk_b($sformatf("v%0d_kv_low", v), keys_valid, 1'b0);
      wait_done($sformatf("v%0d", v), vecs[v].cycles);
      tick();
      chk_b($sformatf("v%0d_done_pulse", v), done, 1'b0);
      for (int r = 0; r < 14; r++) begin
        if (rds[r].vec == v) read_rk($sformatf("v%0d_rk%0d", v, rds[r].idx), rds[r].idx,
                                     rds[r].exp);
      end
    end

    // Reserved length: rejected, 256-bit schedule untouched.
    key_len = 2'b11; key_in = '1; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    chk_b("rsvd_err", err, 1'b1);
    chk_b("rsvd_kv_kept", keys_valid, 1'b1);
    chk_b("rsvd_busy", busy, 1'b0);
    chk_b("rsvd_ready", key_ready, 1'b1);
    tick();
    chk_b("rsvd_err_pulse", err, 1'b0);
    read_rk("rsvd_rk14", 4'd14, A3_RK14);

    // 128-bit-only instance: A.1 accepted, 256-bit request rejected.
    key_len = 2'b00; key_in = vecs[0].key; key_valid2 = 1'b1;
    tick();
    key_valid2 = 1'b0;
    chk_b("m128_busy", busy2, 1'b1);
    n = 0;
    while (!done2 && n < 100) begin
      tick();
      n++;
    end
    chk_i("m128_done_cycle", n, 40);
    tick();
    key_len = 2'b10; key_in = vecs[2].key; key_valid2 = 1'b1;
    tick();
    key_valid2 = 1'b0;
    chk_b("m128_err", err2, 1'b1);
    chk_b("m128_kv_kept", keys_valid2, 1'b1);
    chk_b("m128_busy_idle", busy2, 1'b0);
    tick();
    chk_b("m128_err_pulse", err2, 1'b0);
    rk_rd_en = 1'b1; rk_rd_idx = 4'd10;
    tick();
    rk_rd_en = 1'b0;
    chk_b("m128_rd_vld", rk_rd_vld2, 1'b1);
    chk_w("m128_rk10", rk_rd_data2, A1_RK10);

    // Reset 20 cycles into an A.1 run, then a clean rerun.
    accept_key(2'b00, vecs[0].key, 1'b0);
    repeat (20) tick();
    chk_b("abort_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    tick();
    check_reset_vals("abort");
    rst_n = 1'b1;
    tick();
    accept_key(2'b00, vecs[0].key, 1'b0);
    wait_done("rerun", 40);
    tick();
    read_rk("rerun_rk10", 4'd10, A1_RK10);

    // Back-to-back 192 then 128 with key_valid held; requests during busy are ignored.
    err_seen = 1'b0;
    accept_key(2'b01, vecs[1].key, 1'b1);
    key_len = 2'b00;
    key_in  = vecs[0].key;
    wait_done("b2b_192", 46);
    tick();
    key_valid = 1'b0;
    chk_b("b2b_second_accept", busy, 1'b1);
    chk_b("b2b_done_pulse", done, 1'b0);
    wait_done("b2b_128", 40);
    chk_b("b2b_no_err", err_seen, 1'b0);
    tick();
    read_rk("b2b_rk12", 4'd12, 128'h0);
    read_rk("b2b_rk10", 4'd10, A1_RK10);
    read_rk("b2b_rk0", 4'd0, A1_KEY);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
